// File: rtl/router_pkg.sv
// Shared types and constants for the router egress path: arbiter state
// encoding, header field positions and the idle grant code.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BODY  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_e;

    localparam int LEN_MSB = 7;
    localparam int LEN_LSB = 2;
    localparam int ADDR_W  = 2;

    localparam logic [1:0] GRANT_NONE = 2'b11;

    // Successor in the 0 -> 1 -> 2 -> 0 ring.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd0) ? 2'd1 : (idx == 2'd1) ? 2'd2 : 2'd0;
    endfunction

endpackage

// File: rtl/router_egress_arb_rr_pick3.sv
// Combinational 3-way round-robin picker: first requester after `last`,
// searched in the order last+1, last+2, last (mod 3).
module rr_pick3
    import router_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any
);

    logic [1:0] base, c1, c2;

    // An out-of-range `last` behaves like 2, so FIFO 0 is tried first.
    assign base = (last == 2'd3) ? 2'd2 : last;
    assign c1   = rr_next(base);
    assign c2   = rr_next(c1);
    assign any  = |req;

    always_comb begin
        grant = GRANT_NONE;
        if (req[c1])
            grant = c1;
        else if (req[c2])
            grant = c2;
        else if (req[base])
            grant = base;
    end

endmodule

// File: rtl/router_egress_arb.sv
// Packet-locked round-robin drain of three FWFT FIFOs onto one egress link,
// with on-the-fly parity check and a stall timeout that soft-resets the FIFO.
module router_egress_arb
    import router_pkg::*;
#(
    parameter int TIMEOUT = 30,
    parameter int DW      = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [2:0]    fifo_empty,
    input  logic [DW-1:0] fifo_dout_0,
    input  logic [DW-1:0] fifo_dout_1,
    input  logic [DW-1:0] fifo_dout_2,
    output logic [2:0]    read_enb,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sop,
    output logic          out_eop,
    output logic          parity_err,
    output logic [2:0]    soft_reset,
    output logic [1:0]    grant
);

    localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    arb_state_e    state, state_nxt;
    logic [1:0]    grant_q, last_q;
    logic [DW-1:0] remain, par_acc;
    logic [SW-1:0] stall;
    logic          parity_err_q;
    logic [2:0]    soft_reset_q;

    logic [1:0]    pick;
    logic          pick_any;
    logic [DW-1:0] head;
    logic          head_empty;
    logic          active, xfer, last_beat, stall_hit;

    rr_pick3 u_pick (
        .req   (~fifo_empty),
        .last  (last_q),
        .grant (pick),
        .any   (pick_any)
    );

    always_comb begin
        head       = '0;
        head_empty = 1'b1;
        case (grant_q)
            2'd0:    begin head = fifo_dout_0; head_empty = fifo_empty[0]; end
            2'd1:    begin head = fifo_dout_1; head_empty = fifo_empty[1]; end
            2'd2:    begin head = fifo_dout_2; head_empty = fifo_empty[2]; end
            default: ;
        endcase
    end

    // Egress beat path is purely combinational from the registered grant.
    always_comb begin
        active    = (state == ST_HDR) || (state == ST_BODY);
        out_valid = active & ~head_empty;
        out_data  = out_valid ? head : '0;
        xfer      = out_valid & out_ready;
        read_enb  = xfer ? (3'b001 << grant_q) : 3'b000;
        last_beat = (state == ST_BODY) && (remain == DW'(1));
        out_sop   = (state == ST_HDR) & out_valid;
        out_eop   = last_beat & out_valid;
        stall_hit = !xfer && (stall == SW'(TIMEOUT - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_any) state_nxt = ST_HDR;
            ST_HDR: begin
                if (xfer)           state_nxt = ST_BODY;
                else if (stall_hit) state_nxt = ST_ABORT;
            end
            ST_BODY: begin
                if (xfer && last_beat) state_nxt = ST_IDLE;
                else if (stall_hit)    state_nxt = ST_ABORT;
            end
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            grant_q      <= GRANT_NONE;
            last_q       <= 2'd2;
            remain       <= '0;
            par_acc      <= '0;
            stall        <= '0;
            parity_err_q <= 1'b0;
            soft_reset_q <= 3'b000;
        end else begin
            parity_err_q <= 1'b0;
            soft_reset_q <= 3'b000;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick;
                        last_q  <= pick;
                        stall   <= '0;
                    end
                end
                ST_HDR, ST_BODY: begin
                    if (xfer) begin
                        stall <= '0;
                        if (state == ST_HDR) begin
                            remain  <= DW'(head[LEN_MSB:LEN_LSB]) + DW'(1);
                            par_acc <= head;
                        end else begin
                            remain  <= remain - DW'(1);
                            par_acc <= par_acc ^ head;
                            if (last_beat) begin
                                parity_err_q <= (par_acc != head);
                                grant_q      <= GRANT_NONE;
                            end
                        end
                    end else if (stall_hit) begin
                        // Pulse lines up with the single ABORT cycle.
                        soft_reset_q <= 3'b001 << grant_q;
                        stall        <= '0;
                    end else begin
                        stall <= stall + SW'(1);
                    end
                end
                ST_ABORT: grant_q <= GRANT_NONE;
                default:  grant_q <= GRANT_NONE;
            endcase
        end
    end

    assign parity_err = parity_err_q;
    assign soft_reset = soft_reset_q;
    assign grant      = grant_q;

endmodule

// File: tb/tb_router_egress_arb.sv
// Scoreboard bench for router_egress_arb: modelled FWFT FIFOs feed the DUT,
// expected beats are queued at push time and compared on each egress transfer.
module tb_router_egress_arb;
    import router_pkg::*;

    logic       clock = 1'b0;
    logic       resetn;
    logic [2:0] fifo_empty;
    logic [7:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
    logic [2:0] read_enb;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_sop, out_eop, parity_err;
    logic [2:0] soft_reset;
    logic [1:0] grant;

    always #5 clock = ~clock;

    router_egress_arb #(.TIMEOUT(30), .DW(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .fifo_empty  (fifo_empty),
        .fifo_dout_0 (fifo_dout_0),
        .fifo_dout_1 (fifo_dout_1),
        .fifo_dout_2 (fifo_dout_2),
        .read_enb    (read_enb),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .parity_err  (parity_err),
        .soft_reset  (soft_reset),
        .grant       (grant)
    );

    typedef struct packed {
        logic [1:0] f;
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       perr;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fq0[$], fq1[$], fq2[$];
    logic [7:0] pl [0:63];

    int   n_cmp = 0, n_err = 0, cyc = 0, last_eop_cyc = 0;
    bit   b2b_mode = 0, have_prev = 0, exp_perr = 0, rnd_ready = 0;
    logic [2:0] rd_l = 3'b000, sr_l = 3'b000;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        fifo_empty  = {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
        fifo_dout_0 = (fq0.size() != 0) ? fq0[0] : 8'h00;
        fifo_dout_1 = (fq1.size() != 0) ? fq1[0] : 8'h00;
        fifo_dout_2 = (fq2.size() != 0) ? fq2[0] : 8'h00;
    endtask

    task automatic fpush(input logic [1:0] f, input logic [7:0] b);
        case (f)
            2'd0:    fq0.push_back(b);
            2'd1:    fq1.push_back(b);
            default: fq2.push_back(b);
        endcase
    endtask

    // Header, pl[0..len-1], then parity (xor of everything before it, or bad_par).
    task automatic push_pkt(input logic [1:0] f, input logic [7:0] hdr,
                            input bit bad, input logic [7:0] bad_par);
        logic [7:0] acc, par;
        int len;
        len = int'(hdr[7:2]);
        acc = hdr;
        fpush(f, hdr);
        exp_q.push_back('{f, hdr, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < len; i++) begin
            acc ^= pl[i];
            fpush(f, pl[i]);
            exp_q.push_back('{f, pl[i], 1'b0, 1'b0, 1'b0});
        end
        par = bad ? bad_par : acc;
        fpush(f, par);
        exp_q.push_back('{f, par, 1'b0, 1'b1, par != acc});
        refresh();
    endtask

    // Negedge sampling: scoreboard compare and parity pulse check.
    task automatic mon_edge();
        beat_t e;
        @(negedge clock);
        cyc++;
        if (!resetn) begin
            rd_l = 3'b000; sr_l = 3'b000; exp_perr = 0;
            return;
        end
        chk("parity_err", parity_err, exp_perr);
        exp_perr = 0;
        rd_l = read_enb;
        sr_l = soft_reset;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("data",  out_data, e.d);
                chk("sop",   out_sop,  e.sop);
                chk("eop",   out_eop,  e.eop);
                chk("grant", grant,    e.f);
                chk("rd_en", read_enb, 3'b001 << e.f);
                exp_perr = e.eop & e.perr;
                if (b2b_mode && e.sop && have_prev) chk("b2b_gap", cyc - last_eop_cyc, 2);
                if (e.eop) begin have_prev = 1; last_eop_cyc = cyc; end
            end
        end else begin
            chk("rd_idle", read_enb, 3'b000);
        end
    endtask

    // Just after the rising edge: apply FIFO pops / soft-reset flushes.
    task automatic adv();
        @(posedge clock);
        #1;
        if (rd_l[0] && fq0.size() != 0) void'(fq0.pop_front());
        if (rd_l[1] && fq1.size() != 0) void'(fq1.pop_front());
        if (rd_l[2] && fq2.size() != 0) void'(fq2.pop_front());
        if (sr_l[0]) fq0.delete();
        if (sr_l[1]) fq1.delete();
        if (sr_l[2]) fq2.delete();
        refresh();
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        mon_edge();
        adv();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || grant !== GRANT_NONE) && k < 400) begin
            step();
            k++;
        end
        chk("drain_done", {exp_q.size() == 0, grant}, {1'b1, GRANT_NONE});
        rnd_ready = 0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic wait_sop(output bit found);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            mon_edge();
            found = out_valid & out_ready & out_sop;
            adv();
        end
        chk("sop_seen", found, 1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk(tag, {grant, out_valid, read_enb, out_sop, out_eop, out_data, parity_err, soft_reset},
            {GRANT_NONE, 18'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        resetn    = 1'b0;
        out_ready = 1'b0;
        refresh();
        repeat (3) step();
        mon_edge();
        check_reset_outs("reset_state");
        adv();
        resetn    = 1'b1;
        out_ready = 1'b1;
        step();

        // Single FIFO 1 packet, len 3, correct parity.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        push_pkt(2'd1, 8'h0D, 0, 8'h00);
        drain();

        // Same packet with parity byte 0x00: error pulse after eop.
        push_pkt(2'd1, 8'h0D, 1, 8'h00);
        drain();

        // len = 0 on FIFO 2.
        push_pkt(2'd2, 8'h02, 0, 8'h00);
        drain();

        // All three busy: served 0, 1, 2, 0 with one idle cycle between.
        b2b_mode = 1; have_prev = 0;
        pl[0] = 8'hAA;
        push_pkt(2'd0, 8'h05, 0, 8'h00);
        pl[0] = 8'h01; pl[1] = 8'h02;
        push_pkt(2'd1, 8'h09, 0, 8'h00);
        push_pkt(2'd2, 8'h02, 0, 8'h00);
        pl[0] = 8'h5A;
        push_pkt(2'd0, 8'h04, 0, 8'h00);
        drain();
        b2b_mode = 0;

        // Random backpressure across two longer packets.
        for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
        push_pkt(2'd1, 8'h1C, 0, 8'h00);
        push_pkt(2'd2, 8'h13, 0, 8'h00);
        rnd_ready = 1;
        drain();

        // Stall 30 cycles after the header: abort with one soft_reset pulse.
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        push_pkt(2'd0, 8'h0D, 0, 8'h00);
        wait_sop(found);
        out_ready = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            mon_edge();
            if (k <= 30)
                chk("stall", {soft_reset, read_enb, grant, out_valid}, {3'b000, 3'b000, 2'd0, 1'b1});
            else if (k == 31)
                chk("abort", {soft_reset, read_enb, out_valid}, {3'b001, 3'b000, 1'b0});
            else
                chk("post_abort", {soft_reset, grant}, {3'b000, GRANT_NONE});
            adv();
        end
        exp_q.delete();
        out_ready = 1'b1;
        repeat (3) step();

        // Reset mid-BODY: everything drops, FIFO 0 served first afterwards.
        push_pkt(2'd1, 8'h0D, 0, 8'h00);
        wait_sop(found);
        mon_edge();
        adv();
        resetn    = 1'b0;
        out_ready = 1'b0;
        step();
        mon_edge();
        check_reset_outs("reset_mid_body");
        exp_q.delete();
        fq0.delete(); fq1.delete(); fq2.delete();
        pl[0] = 8'h77;
        push_pkt(2'd1, 8'h06, 0, 8'h00);
        exp_q.delete();
        fq1.delete();
        pl[0] = 8'h3C;
        push_pkt(2'd0, 8'h04, 0, 8'h00);
        pl[0] = 8'h77;
        push_pkt(2'd1, 8'h06, 0, 8'h00);
        adv();
        resetn    = 1'b1;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
